// File: rtl/jesd204b_rx_link_supervisor.sv
// JESD204B receive link supervisor: reset, SYNC~, SYSREF and buffer-fill sequencing, with bounded retry.
// Latency: a condition sampled on one clk edge changes state and outputs on the next edge.
// Backpressure: none; status-only inputs. Optional err_total counter under JESD_SUP_ERR_CNT_EN.
`timescale 1ns/1ps
module jesd204b_rx_link_supervisor #(
    parameter int RST_CYCLES = 64,
    parameter int TIMEOUT    = 1048575,
    parameter int USEDW_MIN  = 256,
    parameter int USEDW_MAX  = 768,
    parameter int ERR_WINDOW = 65536,
    parameter int ERR_THRESH = 16,
    parameter int MAX_RETRY  = 7
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        enable,
    input  logic        sysref,
    input  logic        adc_sync_b,
    input  logic [9:0]  usedw,
    input  logic [31:0] err_link_rx,
`ifdef JESD_SUP_ERR_CNT_EN
    input  logic        err_total_clr,
    output logic [31:0] err_total,
`endif
    output logic        rx_reset_b,
    output logic        link_up,
    output logic        link_fail,
    output logic [3:0]  retry_cnt,
    output logic [2:0]  state
);
    localparam int WIN_W = (ERR_WINDOW > 1) ? $clog2(ERR_WINDOW) : 1;
    localparam int ERR_W = $clog2(ERR_THRESH + 1);
    localparam logic [19:0]      TIMEOUT_V  = 20'(TIMEOUT);
    localparam logic [19:0]      RST_LAST   = 20'(RST_CYCLES - 1);
    localparam logic [9:0]       USEDW_LO   = 10'(USEDW_MIN);
    localparam logic [9:0]       USEDW_HI   = 10'(USEDW_MAX);
    localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(ERR_WINDOW - 1);
    localparam logic [ERR_W-1:0] ERR_LIMIT  = ERR_W'(ERR_THRESH);
    localparam logic [3:0]       RETRY_LAST = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_RST = 3'd1, S_WSYNC = 3'd2, S_WSYSREF = 3'd3,
        S_WFILL = 3'd4, S_UP = 3'd5, S_FAIL = 3'd6
    } state_e;

    state_e           state_q, state_d;
    logic [19:0]      timer_q, timer_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [ERR_W-1:0] errc_q, errc_d;
    logic [3:0]       retry_cnt_q, retry_cnt_d;
    logic             sysref_q;
    logic             rx_reset_b_q, rx_reset_b_d;
    logic             link_up_q, link_up_d;
    logic             link_fail_q, link_fail_d;
    logic             sysref_rise, err_cyc, timeout, retry_req;

    always_comb begin
        sysref_rise = sysref & ~sysref_q;
        err_cyc     = |err_link_rx;
        timeout     = timer_q >= TIMEOUT_V;
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        win_d       = win_q;
        errc_d      = errc_q;
        retry_req   = 1'b0;
        case (state_q)
            S_IDLE:    state_d = S_RST;
            S_RST:     if (timer_q >= RST_LAST) state_d = S_WSYNC;
            S_WSYNC:   if (adc_sync_b) state_d = S_WSYSREF; else if (timeout) retry_req = 1'b1;
            S_WSYSREF: if (sysref_rise) state_d = S_WFILL; else if (timeout) retry_req = 1'b1;
            S_WFILL:   if (usedw >= USEDW_LO) state_d = S_UP; else if (timeout) retry_req = 1'b1;
            S_UP: begin
                if (!adc_sync_b || usedw < USEDW_LO || usedw > USEDW_HI || errc_q >= ERR_LIMIT) begin
                    retry_req = 1'b1;
                end else if (win_q == WIN_LAST) begin
                    // Window closes; a clean window forgives earlier retries.
                    win_d  = '0;
                    errc_d = '0;
                    if (errc_q == '0 && !err_cyc) retry_cnt_d = 4'd0;
                end else begin
                    win_d = win_q + 1'b1;
                    if (err_cyc && errc_q != '1) errc_d = errc_q + 1'b1;
                end
            end
            S_FAIL:    state_d = S_FAIL;
            default:   state_d = S_IDLE;
        endcase
        if (retry_req) begin
            if (retry_cnt_q == RETRY_LAST) begin
                state_d = S_FAIL;
            end else begin
                retry_cnt_d = retry_cnt_q + 4'd1;
                state_d     = S_RST;
            end
        end
        if (!enable) begin
            state_d     = S_IDLE;
            retry_cnt_d = 4'd0;
        end
        if (state_d != S_UP) begin
            win_d  = '0;
            errc_d = '0;
        end
        if (state_d != state_q) timer_d = '0;
        else if (timer_q != '1) timer_d = timer_q + 20'd1;
        else timer_d = timer_q;
        rx_reset_b_d = (state_d == S_WSYNC) || (state_d == S_WSYSREF) ||
                       (state_d == S_WFILL) || (state_d == S_UP);
        link_up_d    = (state_d == S_UP);
        link_fail_d  = (state_d == S_FAIL);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            win_q        <= '0;
            errc_q       <= '0;
            retry_cnt_q  <= 4'd0;
            sysref_q     <= 1'b0;
            rx_reset_b_q <= 1'b0;
            link_up_q    <= 1'b0;
            link_fail_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            win_q        <= win_d;
            errc_q       <= errc_d;
            retry_cnt_q  <= retry_cnt_d;
            sysref_q     <= sysref;
            rx_reset_b_q <= rx_reset_b_d;
            link_up_q    <= link_up_d;
            link_fail_q  <= link_fail_d;
        end
    end

`ifdef JESD_SUP_ERR_CNT_EN
    logic [31:0] err_total_q, err_total_d;

    always_comb begin
        err_total_d = err_total_q;
        if (err_total_clr) err_total_d = '0;
        else if (state_q == S_UP && err_cyc && err_total_q != '1) err_total_d = err_total_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) err_total_q <= '0;
        else          err_total_q <= err_total_d;
    end

    assign err_total = err_total_q;
`endif

    assign rx_reset_b = rx_reset_b_q;
    assign link_up    = link_up_q;
    assign link_fail  = link_fail_q;
    assign retry_cnt  = retry_cnt_q;
    assign state      = state_q;
endmodule

// File: doc/jesd204b_rx_link_supervisor.md
Name: jesd204b_rx_link_supervisor

Overview:
Link bring-up and recovery controller for the JESD204B receive path (link layer plus elastic buffer). It drives the receive path reset and sequences: reset → wait for SYNC~ release → wait for SYSREF → wait for elastic buffer fill → link up. In link up it monitors link errors, SYNC~ and buffer level, and retries with a bounded count before declaring failure. It sits beside the receive path and takes its status outputs as inputs.

Parameters:
RST_CYCLES, 64, cycles rx_reset_b is held low per attempt (≥1)
TIMEOUT, 1048575, max cycles in each WAIT state before retry (20-bit timer)
USEDW_MIN, 256, lowest legal buffer level in WFILL/UP
USEDW_MAX, 768, highest legal buffer level in UP
ERR_WINDOW, 65536, error-rate window length in cycles
ERR_THRESH, 16, error cycles per window that force resync (≥1)
MAX_RETRY, 7, attempts before FAIL (≤15)

Ports:
clk  input  1  system clock
reset_b  input  1  asynchronous active-low reset
enable  input  1  1 = run bring-up; 0 = hold idle
sysref  input  1  SYSREF, synchronous to clk
adc_sync_b  input  1  SYNC~ from receive path
usedw  input  10  elastic buffer fill level
err_link_rx  input  32  link error flags; any bit set = one error cycle
rx_reset_b  output  1  active-low reset to receive path
link_up  output  1  link established and healthy
link_fail  output  1  retries exhausted
retry_cnt  output  4  attempts used
state  output  3  current FSM state code

Behaviour:
- Only one clock domain, clk. reset_b asserts asynchronously and releases on a clk edge.
- Values while reset_b=0: state=IDLE, rx_reset_b=0, link_up=0, link_fail=0, retry_cnt=0, timer=0, window and error counters=0, sysref_d=0.
- State codes: IDLE=0, RST=1, WSYNC=2, WSYSREF=3, WFILL=4, UP=5, FAIL=6. Code 7 is illegal and goes to IDLE.
- All outputs are registered. rx_reset_b=1 only in WSYNC, WSYSREF, WFILL and UP. link_up=1 only in UP. link_fail=1 only in FAIL.
- The timer clears on every state change and otherwise increments, saturating.
- SYSREF edge detect: sysref_rise = sysref & ~sysref_d.
- IDLE: enable=1 → RST.
- RST: after RST_CYCLES cycles → WSYNC.
- WSYNC: adc_sync_b=1 → WSYSREF. Timer reaching TIMEOUT → retry.
- WSYSREF: sysref_rise → WFILL. Timer reaching TIMEOUT → retry.
- WFILL: usedw ≥ USEDW_MIN → UP. Timer reaching TIMEOUT → retry.
- UP, fault conditions. Any of the following → retry:
  - adc_sync_b=0;
  - usedw < USEDW_MIN or usedw > USEDW_MAX;
  - the window error count reaches ERR_THRESH.
- UP, error window:
  - The window counter runs only in UP.
  - The error count increments on each cycle where err_link_rx≠0, saturating.
  - When the window expires, both counters clear. If that window had zero errors, retry_cnt also clears.
- Retry action:
  - If retry_cnt = MAX_RETRY → FAIL.
  - Otherwise retry_cnt+1 and → RST.
- FAIL: held until enable=0.
- enable=0 in any state → IDLE on the next edge. This has priority over every other transition. retry_cnt and all counters clear.
- Simultaneous events:
  - In a WAIT state, success and timeout in the same cycle → success wins.
  - Multiple UP faults in the same cycle → a single retry.
- Latency: a condition sampled on edge n gives its state/output change on edge n+1.
- usedw is unsigned. All comparisons are unsigned.

Optional Feature:
Macro JESD_SUP_ERR_CNT_EN.
- Defined:
  - Adds output err_total (32 bits), a saturating count of cycles with err_link_rx≠0 while in UP.
  - Adds input err_total_clr: 1 clears err_total on the next edge.
  - err_total resets to 0 and is not cleared by enable=0.
- Undefined: neither port exists and no counter logic is generated.

Test Plan:
- Nominal bring-up (RST_CYCLES=4, TIMEOUT=100): enable=1 → rx_reset_b low exactly 4 cycles. Then adc_sync_b=1, sysref pulse, usedw=300 → link_up=1, state=5, retry_cnt=0.
- Sync timeout: adc_sync_b held 0 → at 100 cycles in WSYNC, retry_cnt=1 and rx_reset_b=0 again. Repeat → after 8 attempts link_fail=1, state=6, retry_cnt=7. Then enable=0 → IDLE, retry_cnt=0.
- Error burst (ERR_WINDOW=1000, ERR_THRESH=16): in UP, err_link_rx=1 for 16 cycles → retry on the 17th edge. 15 error cycles → stays UP, and the counter clears at window end.
- Buffer drift in UP: usedw=769 → exit UP next edge with retry_cnt+1. usedw=768 → stays UP.
- Mid-operation reset and enable drop: reset_b=0 in WFILL → all outputs at reset values immediately. enable=0 in UP → IDLE next edge, link_up=0.
- Simultaneous events: sysref_rise on the same cycle the timer reaches TIMEOUT in WSYSREF → WFILL, no retry. With JESD_SUP_ERR_CNT_EN, 5 error cycles in UP → err_total=5; err_total_clr → 0.
